// File: rtl/button_pulse_repeat.sv
// rtl/button_pulse_repeat.sv - per-button press pulse, hold detect and auto-repeat
// Converts debounced button levels into single-cycle command pulses plus a held flag.
module button_pulse_repeat #(
    parameter int N             = 4,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int REPEAT_EN     = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] pulse,
    output logic [N-1:0] held,
    output logic         any_pulse
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] HOLD_TC   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_TC = CW'(REPEAT_CYCLES - 1);
    localparam logic          RPT_ON    = (REPEAT_EN != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESSED,
        S_REPEAT
    } state_t;

    // Resets to all ones so a button held through reset is not seen as a new press.
    logic [N-1:0] btn_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q <= '1;
        end else begin
            btn_q <= btn_in;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        state_t        state;
        logic [CW-1:0] cnt;
        logic          pulse_r;
        logic          held_r;
        logic          press;

        assign press = btn_in[i] & ~btn_q[i] & en;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state   <= S_IDLE;
                cnt     <= '0;
                pulse_r <= 1'b0;
                held_r  <= 1'b0;
            end else begin
                pulse_r <= 1'b0;
                if (!en) begin
                    state  <= S_IDLE;
                    cnt    <= '0;
                    held_r <= 1'b0;
                end else begin
                    case (state)
                        S_IDLE: begin
                            if (press) begin
                                pulse_r <= 1'b1;
                                cnt     <= '0;
                                state   <= S_PRESSED;
                            end
                        end
                        S_PRESSED: begin
                            // Release wins over terminal count on the same edge.
                            if (!btn_in[i]) begin
                                cnt   <= '0;
                                state <= S_IDLE;
                            end else if (cnt == HOLD_TC) begin
                                held_r  <= 1'b1;
                                cnt     <= '0;
                                pulse_r <= RPT_ON;
                                state   <= S_REPEAT;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                        S_REPEAT: begin
                            if (!btn_in[i]) begin
                                held_r <= 1'b0;
                                cnt    <= '0;
                                state  <= S_IDLE;
                            end else if (RPT_ON) begin
                                if (cnt == REPEAT_TC) begin
                                    pulse_r <= 1'b1;
                                    cnt     <= '0;
                                end else begin
                                    cnt <= cnt + CW'(1);
                                end
                            end
                        end
                        default: begin
                            state  <= S_IDLE;
                            cnt    <= '0;
                            held_r <= 1'b0;
                        end
                    endcase
                end
            end
        end

        assign pulse[i] = pulse_r;
        assign held[i]  = held_r;
    end

    assign any_pulse = |pulse;

endmodule

// File: tb/tb_button_pulse_repeat.sv
// tb/tb_button_pulse_repeat.sv - self-checking bench for button_pulse_repeat
module tb_button_pulse_repeat;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] btn;
    logic [3:0] btn0;
    logic [3:0] pulse, held;
    logic [3:0] pulse0, held0;
    logic       any_pulse, any_pulse0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    button_pulse_repeat #(.N(4), .HOLD_CYCLES(8), .REPEAT_CYCLES(4), .REPEAT_EN(1)) dut (
        .clk(clk), .reset(reset), .en(en), .btn_in(btn),
        .pulse(pulse), .held(held), .any_pulse(any_pulse)
    );

    button_pulse_repeat #(.N(4), .HOLD_CYCLES(8), .REPEAT_CYCLES(4), .REPEAT_EN(0)) dut0 (
        .clk(clk), .reset(reset), .en(en), .btn_in(btn0),
        .pulse(pulse0), .held(held0), .any_pulse(any_pulse0)
    );

    typedef struct {
        logic       en;
        logic [3:0] btn;
        logic [3:0] p;
        logic [3:0] h;
        int         reps;
    } vec_t;

    typedef struct {
        logic [3:0] p;
        logic [3:0] h;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic void add(input logic e, input logic [3:0] b, input logic [3:0] p,
                                input logic [3:0] h, input int reps);
        vec_t v;
        v.en = e; v.btn = b; v.p = p; v.h = h; v.reps = reps;
        tbl.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [3:0] ap, input logic [3:0] ah, input logic aa);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", nm);
            return;
        end
        e = sb.pop_front();
        if (ap !== e.p) begin
            n_fail++;
            $display("FAIL %s pulse: got %b expected %b", nm, ap, e.p);
        end
        n_tests++;
        if (ah !== e.h) begin
            n_fail++;
            $display("FAIL %s held: got %b expected %b", nm, ah, e.h);
        end
        n_tests++;
        if (aa !== (|e.p)) begin
            n_fail++;
            $display("FAIL %s any_pulse: got %b expected %b", nm, aa, |e.p);
        end
    endtask

    // Drive one cycle of stimulus, record expectation, sample 1 time unit after the edge.
    task automatic step(input logic sel0, input logic e, input logic [3:0] b,
                        input logic [3:0] ep, input logic [3:0] eh, input string nm);
        exp_t x;
        en = e;
        if (sel0) btn0 = b; else btn = b;
        x.p = ep; x.h = eh;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sel0) check(nm, pulse0, held0, any_pulse0);
        else      check(nm, pulse, held, any_pulse);
    endtask

    initial begin
        exp_t x;
        reset = 1'b1; en = 1'b1; btn = '0; btn0 = '0;
        repeat (2) @(posedge clk);
        #1;
        x.p = '0; x.h = '0;
        sb.push_back(x); check("reset_state", pulse, held, any_pulse);
        sb.push_back(x); check("reset_state0", pulse0, held0, any_pulse0);
        reset = 1'b0;

        // idle, then short press on channel 0
        add(1, 4'b0000, 4'b0000, 4'b0000, 2);
        add(1, 4'b0001, 4'b0001, 4'b0000, 1);
        add(1, 4'b0001, 4'b0000, 4'b0000, 4);
        add(1, 4'b0000, 4'b0000, 4'b0000, 2);
        // long hold on channel 1: pulses at 0, 8, 12, 16
        add(1, 4'b0010, 4'b0010, 4'b0000, 1);
        add(1, 4'b0010, 4'b0000, 4'b0000, 7);
        add(1, 4'b0010, 4'b0010, 4'b0010, 1);
        add(1, 4'b0010, 4'b0000, 4'b0010, 3);
        add(1, 4'b0010, 4'b0010, 4'b0010, 1);
        add(1, 4'b0010, 4'b0000, 4'b0010, 3);
        add(1, 4'b0010, 4'b0010, 4'b0010, 1);
        add(1, 4'b0010, 4'b0000, 4'b0010, 3);
        add(1, 4'b0000, 4'b0000, 4'b0000, 2);
        // release exactly at terminal count on channel 2, then a fresh press
        add(1, 4'b0100, 4'b0100, 4'b0000, 1);
        add(1, 4'b0100, 4'b0000, 4'b0000, 7);
        add(1, 4'b0000, 4'b0000, 4'b0000, 2);
        add(1, 4'b0100, 4'b0100, 4'b0000, 1);
        add(1, 4'b0000, 4'b0000, 4'b0000, 1);
        // en gating on channel 3
        add(1, 4'b1000, 4'b1000, 4'b0000, 1);
        add(1, 4'b1000, 4'b0000, 4'b0000, 7);
        add(1, 4'b1000, 4'b1000, 4'b1000, 1);
        add(1, 4'b1000, 4'b0000, 4'b1000, 1);
        add(0, 4'b1000, 4'b0000, 4'b0000, 5);
        add(1, 4'b1000, 4'b0000, 4'b0000, 5);
        add(1, 4'b0000, 4'b0000, 4'b0000, 1);
        add(1, 4'b1000, 4'b1000, 4'b0000, 1);
        add(1, 4'b0000, 4'b0000, 4'b0000, 2);
        // simultaneous presses
        add(1, 4'b0011, 4'b0011, 4'b0000, 1);
        add(1, 4'b0000, 4'b0000, 4'b0000, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                step(1'b0, tbl[i].en, tbl[i].btn, tbl[i].p, tbl[i].h, $sformatf("vec%0d.%0d", i, r));
            end
        end

        // button held across reset deassertion
        btn = 4'b0101; reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int j = 0; j < 5; j++) step(1'b0, 1, 4'b0101, 4'b0000, 4'b0000, "held_thru_reset");
        step(1'b0, 1, 4'b0000, 4'b0000, 4'b0000, "held_thru_reset_rel");

        // reset asserted mid-REPEAT while a pulse is high
        step(1'b0, 1, 4'b0010, 4'b0010, 4'b0000, "midrep_p0");
        for (int j = 1; j < 8; j++) step(1'b0, 1, 4'b0010, 4'b0000, 4'b0000, "midrep_hold");
        step(1'b0, 1, 4'b0010, 4'b0010, 4'b0010, "midrep_p8");
        for (int j = 9; j < 12; j++) step(1'b0, 1, 4'b0010, 4'b0000, 4'b0010, "midrep_rep");
        step(1'b0, 1, 4'b0010, 4'b0010, 4'b0010, "midrep_p12");
        reset = 1'b1;
        #1;
        x.p = '0; x.h = '0;
        sb.push_back(x); check("async_reset", pulse, held, any_pulse);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int j = 0; j < 4; j++) step(1'b0, 1, 4'b0010, 4'b0000, 4'b0000, "post_reset_held");
        step(1'b0, 1, 4'b0000, 4'b0000, 4'b0000, "post_reset_rel");
        step(1'b0, 1, 4'b0010, 4'b0010, 4'b0000, "post_reset_press");
        step(1'b0, 1, 4'b0000, 4'b0000, 4'b0000, "post_reset_idle");

        // REPEAT_EN = 0 instance, all four channels together
        step(1'b1, 1, 4'b0000, 4'b0000, 4'b0000, "norep_idle");
        for (int j = 0; j < 20; j++) begin
            step(1'b1, 1, 4'b1111, (j == 0) ? 4'b1111 : 4'b0000,
                 (j >= 8) ? 4'b1111 : 4'b0000, $sformatf("norep_j%0d", j));
        end
        step(1'b1, 1, 4'b0000, 4'b0000, 4'b0000, "norep_rel");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/button_pulse_repeat.md
Name: button_pulse_repeat

Overview:
- Consumes the debounced, synchronised button levels from the per-button debouncers and converts each into single-cycle command pulses for the control FSM (time/date setting).
- Per button: one pulse on press; after a hold period, optional auto-repeat pulses at a fixed rate; a "held" status flag.
- N independent per-button channels share only clock, reset and enable.

Parameters:
- N, 4, number of button channels.
- HOLD_CYCLES, 50000000, cycles from press pulse to first repeat pulse/held assertion (0.5 s at 100 MHz); must be >= 2.
- REPEAT_CYCLES, 10000000, cycles between consecutive repeat pulses; must be >= 1.
- REPEAT_EN, 1, 1 = auto-repeat enabled; 0 = single pulse per press, held flag still works.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- en  input  1  accept presses when 1; when 0, channels are forced idle.
- btn_in  input  N  debounced button levels, 1 = pressed; already synchronous to clk.
- pulse  output  N  one-cycle command pulse per channel, registered.
- held  output  N  1 while the button has been held >= HOLD_CYCLES, registered.
- any_pulse  output  1  OR of pulse[N-1:0], combinational from registered pulses.

Behaviour:
- Reset (async, active-high): every channel in IDLE, counter = 0, pulse = 0, held = 0, any_pulse = 0, prev-sample register btn_q = all ones. A button held through reset produces no pulse until released and pressed again.
- btn_q[i] <= btn_in[i] every cycle, regardless of state or en.
- Press event: press[i] = btn_in[i] & ~btn_q[i] & en.
- Counter per channel: width ceil(log2(max(HOLD_CYCLES, REPEAT_CYCLES))) + 1; never wraps, because it is cleared on every state change or pulse.
- pulse defaults to 0 each cycle; it is set only where stated below.
- IDLE: on press: pulse <= 1, counter <= 0, go to PRESSED. Otherwise stay.
- PRESSED:
  - btn_in = 0: go to IDLE.
  - else, counter == HOLD_CYCLES-1: held <= 1, counter <= 0, pulse <= REPEAT_EN, go to REPEAT.
  - else: counter++.
- REPEAT:
  - btn_in = 0: held <= 0, go to IDLE.
  - else, REPEAT_EN = 1 and counter == REPEAT_CYCLES-1: pulse <= 1, counter <= 0.
  - else, REPEAT_EN = 1: counter++.
  - else (REPEAT_EN = 0): counter holds.
- Timing: if the press is sampled at edge k, pulses are high in the cycle after edges k, k+HOLD_CYCLES, k+HOLD_CYCLES+REPEAT_CYCLES, then every REPEAT_CYCLES. held rises together with the second pulse.
- Release has priority over terminal count in the same cycle: no pulse, state goes to IDLE, held <= 0 on that edge.
- en = 0 in any state: next state IDLE, held <= 0, counter <= 0, pulse <= 0. Re-asserting en while the button is still held gives no pulse; a release and new press is required.
- Channels are fully independent; simultaneous presses on several channels give simultaneous pulses.
- Reset mid-hold: outputs clear immediately (asynchronously). After reset deasserts with the button still pressed, there is no pulse.

Test Plan (N=4, HOLD_CYCLES=8, REPEAT_CYCLES=4, REPEAT_EN=1 unless stated):
- Short press: btn_in[0] high for 5 cycles after reset, en=1 -> exactly one pulse[0], 1 cycle wide, 1 cycle after the sampling edge; held[0] stays 0; any_pulse mirrors pulse[0].
- Long hold: btn_in[1] high for 20 cycles -> pulse[1] at relative cycles 0, 8, 12, 16; held[1] rises at 8 and falls 1 cycle after release.
- Release at terminal count: btn_in[2] drops exactly at the edge where counter == 7 -> no second pulse, held[2] never asserts, channel returns to IDLE.
- en gating: hold btn_in[3], drop en at relative cycle 10, raise it at cycle 15 while still held -> pulses only at cycles 0 and 8, held clears at 10, no pulse after en returns; a release followed by a press gives a pulse.
- Reset behaviour: btn_in=4'b0101 held across reset deassertion -> no pulses. Assert reset mid-REPEAT -> pulse and held drop to 0 asynchronously.
- REPEAT_EN=0, simultaneous channels: btn_in=4'b1111 for 20 cycles -> one pulse on all four channels in the same cycle, held=4'b1111 from cycle 8, no further pulses.
